sr_rw_engine: RTL and testbench

Multi-chain, parametrised shift-register write/readback engine for TMII-family configuration registers. On `start` it serially shifts a new word into each of `NCH` on-chip shift-register chains while capturing the bits they shift out, then pulses the chip load strobe and presents the recovered words. It also flags any chain whose readback differs from the word written in the previous transaction. It sits between the register-file/control FSM and the chip pads, replacing the fixed-width, single-chain receive path.

---
 rtl/sr_rw_pkg.sv | 26 ++
 rtl/sr_clk_gen.sv | 57 +++++
 rtl/sr_rw_engine.sv | 128 ++++++++++++
 tb/tb_sr_rw_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_rw_pkg.sv
// Shared definitions for the shift-register write/readback engine:
// one-hot state encoding and a constant clog2 helper for counter sizing.
package sr_rw_pkg;

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_SHIFT = 4'b0010;
    localparam logic [3:0] S_LOAD  = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_LOAD  = S_LOAD,
        ST_DONE  = S_DONE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sr_clk_gen.sv
// Phase and bit counters for the serial link; produces the registered
// shift clock plus the sample/advance strobes consumed by the engine FSM.
module sr_clk_gen
    import sr_rw_pkg::*;
#(
    parameter int DATA_WIDTH = 170,
    parameter int DIV        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic shift,
    output logic sr_clk,
    output logic sample_en,
    output logic bit_adv,
    output logic last_bit
);

    localparam int PW = clog2(2 * DIV);
    localparam int BW = clog2(DATA_WIDTH + 1);
    localparam logic [PW-1:0] PH_LOW_END = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_END     = PW'(2 * DIV - 1);
    localparam logic [BW-1:0] BIT_END    = BW'(DATA_WIDTH - 1);

    logic [PW-1:0] phase;
    logic [BW-1:0] bit_cnt;

    assign sample_en = en && (phase == PH_LOW_END);
    assign bit_adv   = en && (phase == PH_END);
    assign last_bit  = (bit_cnt == BIT_END);

    // Counters also run through LOAD so its length reuses the low-phase strobe.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            phase   <= '0;
            bit_cnt <= '0;
        end else begin
            if (phase == PH_END) begin
                phase   <= '0;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !shift) begin
            sr_clk <= 1'b0;
        end else if (phase == PH_LOW_END) begin
            sr_clk <= 1'b1;
        end else if (phase == PH_END) begin
            sr_clk <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_rw_engine.sv
// Multi-chain serial write/readback engine: shifts a word into each chain,
// captures what falls out, strobes load and flags readback vs. last write.
module sr_rw_engine
    import sr_rw_pkg::*;
#(
    parameter int DATA_WIDTH = 170,
    parameter int NCH        = 2,
    parameter int DIV        = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      lsb_first,
    input  logic [NCH*DATA_WIDTH-1:0] din,
    output logic                      busy,
    output logic                      done,
    output logic [NCH*DATA_WIDTH-1:0] dout,
    output logic [NCH-1:0]            mismatch,
    output logic                      sr_clk,
    output logic [NCH-1:0]            sr_din,
    output logic                      sr_load,
    input  logic [NCH-1:0]            sr_dout
);

    state_t state, state_next;
    logic   order_lsb;
    logic   shadow_valid;
    logic   sample_en, bit_adv, last_bit;
    logic   count_en, shift_en, accept, capture;

    assign shift_en = (state == ST_SHIFT);
    assign count_en = (state == ST_SHIFT) || (state == ST_LOAD);
    assign accept   = (state == ST_IDLE) && start;
    assign capture  = (state == ST_LOAD) && sample_en;

    sr_clk_gen #(
        .DATA_WIDTH(DATA_WIDTH),
        .DIV       (DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (count_en),
        .shift    (shift_en),
        .sr_clk   (sr_clk),
        .sample_en(sample_en),
        .bit_adv  (bit_adv),
        .last_bit (last_bit)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (bit_adv && last_bit) state_next = ST_LOAD;
            ST_LOAD:  if (sample_en) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Status strobes are decoded from the next state so they leave a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            sr_load      <= 1'b0;
            order_lsb    <= 1'b0;
            shadow_valid <= 1'b0;
        end else begin
            state   <= state_next;
            busy    <= (state_next != ST_IDLE);
            done    <= (state_next == ST_DONE);
            sr_load <= (state_next == ST_LOAD);
            if (accept) order_lsb <= lsb_first;
            if (capture) shadow_valid <= 1'b1;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chain
        logic [DATA_WIDTH-1:0] din_c;
        logic [DATA_WIDTH-1:0] tx_word;
        logic [DATA_WIDTH-1:0] rx_word;
        logic [DATA_WIDTH-1:0] shadow;
        logic [DATA_WIDTH-1:0] rd_word;
        logic                  ser_bit;
        logic                  miss;

        assign din_c = din[c*DATA_WIDTH +: DATA_WIDTH];
        assign dout[c*DATA_WIDTH +: DATA_WIDTH] = rd_word;
        assign mismatch[c] = miss;
        assign sr_din[c]   = ser_bit;

        // tx_word rotates rather than shifts, so after a full word it holds the
        // written value again and can refresh the shadow directly.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                tx_word <= '0;
                rx_word <= '0;
                shadow  <= '0;
                rd_word <= '0;
                ser_bit <= 1'b0;
                miss    <= 1'b0;
            end else begin
                if (accept) begin
                    tx_word <= din_c;
                    ser_bit <= lsb_first ? din_c[0] : din_c[DATA_WIDTH-1];
                end
                if (shift_en && sample_en) begin
                    rx_word <= order_lsb ? {sr_dout[c], rx_word[DATA_WIDTH-1:1]}
                                         : {rx_word[DATA_WIDTH-2:0], sr_dout[c]};
                end
                if (shift_en && bit_adv) begin
                    tx_word <= order_lsb ? {tx_word[0], tx_word[DATA_WIDTH-1:1]}
                                         : {tx_word[DATA_WIDTH-2:0], tx_word[DATA_WIDTH-1]};
                    ser_bit <= last_bit ? 1'b0
                             : (order_lsb ? tx_word[1] : tx_word[DATA_WIDTH-2]);
                end
                if (capture) begin
                    rd_word <= rx_word;
                    miss    <= shadow_valid && (rx_word != shadow);
                    shadow  <= tx_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_sr_rw_engine.sv
// Self-checking bench for sr_rw_engine with a behavioural chip model per chain
// and a word-level reference model of readback order and mismatch flags.
module tb_sr_rw_engine;

    localparam int DW      = 8;
    localparam int NCH     = 2;
    localparam int DIV     = 2;
    localparam int LATENCY = 1 + 2 * DIV * DW + DIV;
    localparam int LIMIT   = 200;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              lsb_first;
    logic [NCH*DW-1:0] din;
    logic              busy;
    logic              done;
    logic [NCH*DW-1:0] dout;
    logic [NCH-1:0]    mismatch;
    logic              sr_clk;
    logic [NCH-1:0]    sr_din;
    logic              sr_load;
    logic [NCH-1:0]    sr_dout;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] chip [NCH] = '{default: '0};
    int rises      = 0;
    int rise_base  = 0;
    int flip_chain = -1;
    int flip_bit   = 0;

    logic [DW-1:0] model_word  [NCH];
    logic [DW-1:0] shadow_word [NCH];
    logic          model_lsb;
    logic          model_valid;
    logic          chip_known;

    sr_rw_engine #(
        .DATA_WIDTH(DW),
        .NCH       (NCH),
        .DIV       (DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .lsb_first(lsb_first),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .mismatch (mismatch),
        .sr_clk   (sr_clk),
        .sr_din   (sr_din),
        .sr_load  (sr_load),
        .sr_dout  (sr_dout)
    );

    always #5 clk = ~clk;

    // Chip: plain shift register, MSB drives the return line.
    always @(posedge sr_clk) begin
        for (int c = 0; c < NCH; c++) chip[c] <= {chip[c][DW-2:0], sr_din[c]};
        rises <= rises + 1;
    end

    always_comb begin
        for (int c = 0; c < NCH; c++)
            sr_dout[c] = chip[c][DW-1] ^ ((c == flip_chain) && ((rises - rise_base) == flip_bit));
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] reverse_bits(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
        return r;
    endfunction

    // Chain returns bits in the order they went in; the stored index depends on
    // the order of the reading transaction, so differing orders mirror the word.
    task automatic model_step(input logic [NCH*DW-1:0] word, input logic lsb,
                              input int fchain, input int fbit,
                              output logic [NCH*DW-1:0] exp_dout,
                              output logic [NCH-1:0] exp_mis);
        for (int c = 0; c < NCH; c++) begin
            logic [DW-1:0] rd;
            rd = (lsb == model_lsb) ? model_word[c] : reverse_bits(model_word[c]);
            if (fchain == c) rd[lsb ? fbit : DW - 1 - fbit] = ~rd[lsb ? fbit : DW - 1 - fbit];
            exp_dout[c*DW +: DW] = rd;
            exp_mis[c] = model_valid && (rd != shadow_word[c]);
            model_word[c]  = word[c*DW +: DW];
            shadow_word[c] = word[c*DW +: DW];
        end
        model_lsb   = lsb;
        model_valid = 1'b1;
    endtask

    task automatic wait_done(input bit drop, output int lat, output int clk_hi,
                             output int load_cnt, output logic [NCH-1:0] first_din,
                             output logic first_busy);
        lat = 0; clk_hi = 0; load_cnt = 0; first_din = '0; first_busy = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                first_din  = sr_din;
                first_busy = busy;
                if (drop) start = 1'b0;
            end
            if (sr_clk) clk_hi++;
            if (sr_load) load_cnt++;
        end while (!done && lat < LIMIT);
    endtask

    task automatic check_txn(input string name, input int lat, input int clk_hi,
                             input int load_cnt, input logic first_busy,
                             input logic [NCH*DW-1:0] exp_dout, input logic [NCH-1:0] exp_mis);
        check_output({name, ".latency"}, lat, LATENCY);
        check_output({name, ".busy"}, first_busy, 1'b1);
        check_output({name, ".clk_high"}, clk_hi, DIV * DW);
        check_output({name, ".load_len"}, load_cnt, DIV);
        if (chip_known) check_output({name, ".dout"}, dout, exp_dout);
        check_output({name, ".mismatch"}, mismatch, exp_mis);
        chip_known = 1'b1;
    endtask

    task automatic apply_stimulus(input string name, input logic [NCH*DW-1:0] word,
                                  input logic lsb, input int fchain, input int fbit,
                                  input bit hold);
        logic [NCH*DW-1:0] exp_dout;
        logic [NCH-1:0]    exp_mis, exp_first, first_din;
        logic              first_busy;
        int                lat, clk_hi, load_cnt;
        @(negedge clk);
        din = word; lsb_first = lsb; start = 1'b1;
        flip_chain = fchain; flip_bit = fbit; rise_base = rises;
        for (int c = 0; c < NCH; c++) exp_first[c] = lsb ? word[c*DW] : word[c*DW+DW-1];
        model_step(word, lsb, fchain, fbit, exp_dout, exp_mis);
        wait_done(!hold, lat, clk_hi, load_cnt, first_din, first_busy);
        check_output({name, ".first_bit"}, first_din, exp_first);
        check_txn(name, lat, clk_hi, load_cnt, first_busy, exp_dout, exp_mis);
    endtask

    initial begin
        logic [NCH*DW-1:0] word, exp_dout;
        logic [NCH-1:0]    exp_mis, first_din;
        logic              first_busy;
        int                lat, clk_hi, load_cnt, done_cnt;

        rst_n = 1'b0; start = 1'b0; lsb_first = 1'b0; din = '0;
        for (int c = 0; c < NCH; c++) begin
            model_word[c] = '0; shadow_word[c] = '0;
        end
        model_lsb = 1'b1; model_valid = 1'b0; chip_known = 1'b1;

        repeat (3) @(negedge clk);
        check_output("reset.ctrl", {busy, done, sr_clk, sr_load, sr_din}, '0);
        check_output("reset.data", {dout, mismatch}, '0);
        rst_n = 1'b1;

        apply_stimulus("first", {8'h3C, 8'hA5}, 1'b1, -1, 0, 1'b0);
        apply_stimulus("second", {8'h00, 8'hFF}, 1'b1, -1, 0, 1'b0);
        apply_stimulus("corrupt", {8'h5A, 8'h69}, 1'b1, 1, 3, 1'b0);
        apply_stimulus("msb", {8'h80, 8'h80}, 1'b0, -1, 0, 1'b0);
        exp_dout = dout;
        repeat (3) @(negedge clk);
        check_output("hold.dout", dout, exp_dout);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus($sformatf("rand%0d", i), (NCH*DW)'($urandom), 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 2)) - 1, int'($urandom_range(0, DW - 1)), 1'b0);
        end

        // start held high across two transactions
        word = (NCH*DW)'($urandom);
        apply_stimulus("held1", word, 1'b1, -1, 0, 1'b1);
        @(negedge clk);
        check_output("held.gap_busy", busy, 1'b0);
        check_output("held.done_pulse", done, 1'b0);
        flip_chain = -1; rise_base = rises;
        model_step(word, 1'b1, -1, 0, exp_dout, exp_mis);
        wait_done(1'b1, lat, clk_hi, load_cnt, first_din, first_busy);
        check_txn("held2", lat, clk_hi, load_cnt, first_busy, exp_dout, exp_mis);
        repeat (3) @(negedge clk);
        check_output("held.single", busy, 1'b0);

        // abort mid-shift
        @(negedge clk);
        din = (NCH*DW)'($urandom); lsb_first = 1'b1; start = 1'b1;
        flip_chain = -1; rise_base = rises;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("abort.ctrl", {busy, done, sr_clk, sr_load, sr_din}, '0);
        check_output("abort.data", {dout, mismatch}, '0);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_output("abort.no_done", done_cnt, 0);
        model_valid = 1'b0; chip_known = 1'b0;

        apply_stimulus("post_abort", (NCH*DW)'($urandom), 1'b1, -1, 0, 1'b0);
        apply_stimulus("resync", (NCH*DW)'($urandom), 1'b0, 0, 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
